// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   - arb_state_e : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   - M0 / M1     : owner and last_grant encoding (core port / loader port)
//   - WAIT_W      : width of the wait-state counter (covers 0..15)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way picker used by dmem_arbiter in its IDLE state.
//   Ports:
//     req[1:0]   in   request vector, bit 0 = master 0, bit 1 = master 1
//     last_grant in   master that won the previous arbitration
//     valid      out  at least one request is present
//     winner     out  index of the chosen master (M0 / M1)
//   Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, master 0 wins every tie
//     undefined -> round-robin, the master other than last_grant wins a tie
// -----------------------------------------------------------------------------
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // History is irrelevant in fixed-priority mode.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        valid  = |req;
        winner = M0;
        if (req == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            winner = M0;
`else
            winner = ~last_grant;
`endif
        end else if (req[1]) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the core load/store path
//   (master 0) and a loader/debug port (master 1). One access at a time:
//   IDLE arbitrates and latches the winner's request, ACCESS drives the
//   memory for WAIT_STATES+1 cycles, RESP returns a one-cycle rvalid.
//
//   Handshake: a master raises mX_req with we/addr/wdata stable and keeps it
//   high until it sees mX_gnt (a one-cycle pulse meaning the fields have been
//   latched). It must drop req, or present its next request, by the cycle
//   after gnt. Completion is signalled by a one-cycle mX_rvalid; load data is
//   on mX_rdata with it and held until the next load completes.
//
//   Parameters: ADDR_W, DATA_W, WAIT_STATES (0..15 extra access cycles)
//   Ports:
//     clk, reset (async, active low)
//     m0_* / m1_* : req, we, addr, wdata in; gnt, rvalid, rdata out
//     mem_addr, mem_wdata, mem_rd_en, mem_wr_en out; mem_rdata in (comb)
//     state_dbg   : current sequencer state, for observation only
//   Configuration macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, m0 wins ties;
//   last_grant is then not kept).
//
//   Every output is a flop, so nothing on a request input reaches gnt or the
//   memory pins in the same cycle.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,

    output arb_state_e        state_dbg
);

    localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

    arb_state_e        state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              owner_q;
    logic              we_q;
    logic [DATA_W-1:0] resp_q;
    logic              last_grant;

    logic              pick_valid;
    logic              pick_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign last_grant = M1;
`else
    logic last_grant_q;
    assign last_grant = last_grant_q;
`endif

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Request fields of whichever master the picker chose.
    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (pick_winner == M1) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= M0;
            we_q         <= 1'b0;
            resp_q       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            m0_gnt       <= 1'b0;
            m1_gnt       <= 1'b0;
            m0_rvalid    <= 1'b0;
            m1_rvalid    <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant_q <= M1;
`endif
        end else begin
            // gnt and rvalid are single-cycle pulses.
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q   <= pick_winner;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        cnt_q     <= WS;
                        m0_gnt    <= (pick_winner == M0);
                        m1_gnt    <= (pick_winner == M1);
                        mem_rd_en <= ~sel_we;
                        // With no wait states the first ACCESS cycle is
                        // also the last, so the write strobe starts here.
                        mem_wr_en <= sel_we && (WS == '0);
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_grant_q <= pick_winner;
`endif
                        state_q   <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt_q == '0) begin
                        // Final cycle: memory has had WAIT_STATES+1 cycles.
                        if (!we_q) begin
                            resp_q <= mem_rdata;
                        end
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        m0_rvalid <= (owner_q == M0);
                        m1_rvalid <= (owner_q == M1);
                        state_q   <= RESP;
                    end else begin
                        cnt_q     <= cnt_q - WAIT_W'(1);
                        // Raise the strobe for the cycle where cnt_q hits 0,
                        // so each store writes exactly once.
                        mem_wr_en <= we_q && (cnt_q == WAIT_W'(1));
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One shared response register feeds both channels.
    assign m0_rdata  = resp_q;
    assign m1_rdata  = resp_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Instance u_a uses WAIT_STATES = 2,
//   instance u_b uses WAIT_STATES = 0. Each has a small word memory model
//   indexed by addr[5:2]. Inputs change and outputs are checked on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A (WAIT_STATES = 2) ----------------
    logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
    logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_rd_en, a_mem_wr_en;
    arb_state_e  a_state;
    logic [31:0] a_mem [16] = '{4: 32'hDEADBEEF, default: 32'h0};

    assign a_mem_rdata = a_mem[a_mem_addr[5:2]];
    always @(posedge clk) if (a_mem_wr_en) a_mem[a_mem_addr[5:2]] <= a_mem_wdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(2)) u_a (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd_en(a_mem_rd_en),
        .mem_wr_en(a_mem_wr_en), .mem_rdata(a_mem_rdata), .state_dbg(a_state)
    );

    // ---------------- instance B (WAIT_STATES = 0) ----------------
    logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_rd_en, b_mem_wr_en;
    arb_state_e  b_state;
    logic [31:0] b_mem [16] = '{1: 32'hCAFEF00D, 2: 32'h0BADC0DE, default: 32'h0};

    assign b_mem_rdata = b_mem[b_mem_addr[5:2]];
    always @(posedge clk) if (b_mem_wr_en) b_mem[b_mem_addr[5:2]] <= b_mem_wdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd_en(b_mem_rd_en),
        .mem_wr_en(b_mem_wr_en), .mem_rdata(b_mem_rdata), .state_dbg(b_state)
    );

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        logic found;
        logic seen;
        int   t1;
        int   t2;

        // Reset held with both masters requesting.
        a_m0_req = 1; a_m1_req = 1;
        a_m0_addr = 32'h10; a_m1_addr = 32'h00;
        step(); step(); step();
        check("rst_m0_gnt",   a_m0_gnt, 0);
        check("rst_m1_gnt",   a_m1_gnt, 0);
        check("rst_rd_en",    a_mem_rd_en, 0);
        check("rst_wr_en",    a_mem_wr_en, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_wdat", a_mem_wdata, 0);
        check("rst_rdata",    a_m0_rdata, 0);
        check("rst_rvalid",   {a_m0_rvalid, a_m1_rvalid}, 0);
        check("rst_state",    a_state, IDLE);
        reset = 1;

        // Contention: both held; expect m0, m1, m0, m1.
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int i = 0; i < 12 && !found; i++) begin
                step();
                if (a_m0_gnt || a_m1_gnt) found = 1;
            end
            check("rr_gnt_seen", found, 1);
            check("rr_gnt_m1",   a_m1_gnt, (k % 2 == 1));
            check("rr_gnt_m0",   a_m0_gnt, (k % 2 == 0));
        end
        a_m0_req = 0; a_m1_req = 0;
        step(); step(); step(); step();
        check("rr_idle", a_state, IDLE);

        // Single load, WAIT_STATES = 2.
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
        step();
        check("ld_gnt",      a_m0_gnt, 1);
        check("ld_m1_gnt",   a_m1_gnt, 0);
        check("ld_rd_en1",   a_mem_rd_en, 1);
        check("ld_wr_en1",   a_mem_wr_en, 0);
        check("ld_addr",     a_mem_addr, 32'h10);
        check("ld_state",    a_state, ACCESS);
        a_m0_req = 0;
        step();
        check("ld_gnt_pulse", a_m0_gnt, 0);
        check("ld_rd_en2",    a_mem_rd_en, 1);
        step();
        check("ld_rd_en3",    a_mem_rd_en, 1);
        check("ld_no_rvalid", a_m0_rvalid, 0);
        step();
        check("ld_rvalid",    a_m0_rvalid, 1);
        check("ld_m1_rvalid", a_m1_rvalid, 0);
        check("ld_rdata",     a_m0_rdata, 32'hDEADBEEF);
        check("ld_rd_en_off", a_mem_rd_en, 0);
        check("ld_resp",      a_state, RESP);
        step();
        check("ld_rvalid_end", a_m0_rvalid, 0);
        check("ld_idle",       a_state, IDLE);

        // Store from m1, WAIT_STATES = 2.
        a_m1_req = 1; a_m1_we = 1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
        step();
        check("st_gnt",    a_m1_gnt, 1);
        check("st_m0_gnt", a_m0_gnt, 0);
        check("st_wr_en1", a_mem_wr_en, 0);
        check("st_rd_en",  a_mem_rd_en, 0);
        check("st_wdata",  a_mem_wdata, 32'h12345678);
        a_m1_req = 0; a_m1_we = 0;
        step();
        check("st_wr_en2", a_mem_wr_en, 0);
        step();
        check("st_wr_en3", a_mem_wr_en, 1);
        check("st_addr",   a_mem_addr, 32'h20);
        step();
        check("st_rvalid",    a_m1_rvalid, 1);
        check("st_m0_rvalid", a_m0_rvalid, 0);
        check("st_wr_en_off", a_mem_wr_en, 0);
        check("st_rdata_hold", a_m1_rdata, 32'hDEADBEEF);
        check("st_mem",       a_mem[8], 32'h12345678);
        step();

        // Readback of the stored word.
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h20;
        step();
        check("rb_gnt", a_m0_gnt, 1);
        a_m0_req = 0;
        step(); step(); step();
        check("rb_rvalid", a_m0_rvalid, 1);
        check("rb_rdata",  a_m0_rdata, 32'h12345678);
        step();

        // Reset during the first ACCESS cycle of a store.
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 32'h30; a_m0_wdata = 32'hAAAA5555;
        step();
        check("rs_gnt", a_m0_gnt, 1);
        a_m0_req = 0; a_m0_we = 0;
        #2 reset = 0;
        #1;
        check("rs_state",    a_state, IDLE);
        check("rs_gnt_clr",  a_m0_gnt, 0);
        check("rs_addr_clr", a_mem_addr, 0);
        check("rs_rdata",    a_m0_rdata, 0);
        seen = 0;
        step();
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_m0_rvalid || a_m1_rvalid || a_mem_wr_en) seen = 1;
        end
        check("rs_no_activity", seen, 0);
        check("rs_mem_kept",    a_mem[12], 0);
        check("rs_idle",        a_state, IDLE);

        // WAIT_STATES = 0: two back-to-back m0 loads.
        t1 = 0; t2 = 0;
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h04;
        step();
        check("b2b_gnt1",   b_m0_gnt, 1);
        check("b2b_rd_en1", b_mem_rd_en, 1);
        check("b2b_state1", b_state, ACCESS);
        b_m0_addr = 32'h08;
        step();
        check("b2b_rvalid1", b_m0_rvalid, 1);
        check("b2b_rdata1",  b_m0_rdata, 32'hCAFEF00D);
        check("b2b_rd_off",  b_mem_rd_en, 0);
        t1 = cyc;
        step();
        check("b2b_idle",    b_state, IDLE);
        check("b2b_gap_gnt", b_m0_gnt, 0);
        step();
        check("b2b_gnt2",  b_m0_gnt, 1);
        check("b2b_addr2", b_mem_addr, 32'h08);
        b_m0_req = 0;
        step();
        check("b2b_rvalid2", b_m0_rvalid, 1);
        check("b2b_rdata2",  b_m0_rdata, 32'h0BADC0DE);
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 3);
        step();

        // WAIT_STATES = 0 store: strobe coincides with gnt.
        b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h0C; b_m1_wdata = 32'h00000055;
        step();
        check("ws0_gnt",   b_m1_gnt, 1);
        check("ws0_wr_en", b_mem_wr_en, 1);
        check("ws0_m0_ch", {b_m0_gnt, b_m0_rvalid}, 0);
        b_m1_req = 0; b_m1_we = 0;
        step();
        check("ws0_rvalid", b_m1_rvalid, 1);
        check("ws0_wr_off", b_mem_wr_en, 0);
        check("ws0_mem",    b_mem[3], 32'h00000055);
        check("ws0_rdata_hold", b_m1_rdata, 32'h0BADC0DE);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
